// File: rtl/slot_game_core.sv
// slot_game_core: coin credit, spin FSM, REELS stoppable reels, match
// evaluation and payout for the one-arm-bandit.
// Optional feature: define SLOT_PAIR_PAY_EN to pay PAIR_PAY on a
// two-of-a-kind result. When it is undefined, only an all-equal result pays
// and no pair comparators are built.

// One reel: loads a start symbol, then advances modulo SYMBOLS when enabled.
module slot_reel #(
  parameter int SYMBOLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       adv,
  output logic [3:0] sym
);

  // Load has priority; the advance wraps SYMBOLS-1 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sym <= '0;
    else if (load)
      sym <= load_val;
    else if (adv)
      sym <= (sym == 4'(SYMBOLS - 1)) ? 4'd0 : sym + 4'd1;
  end

endmodule

module slot_game_core #(
  parameter int          REELS       = 3,
  parameter int          SYMBOLS     = 10,
  parameter int          CREDIT_W    = 8,
  parameter int          CREDIT_MAX  = 99,
  parameter int          SPIN_COST   = 1,
  parameter int          JACKPOT_PAY = 10,
  parameter int          PAIR_PAY    = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coin_p,
  input  logic                  start_p,
  input  logic                  stop_p,
  input  logic                  tick,
  output logic [4*REELS-1:0]    reels,
  output logic [CREDIT_W-1:0]   credit,
  output logic [CREDIT_W-1:0]   payout,
  output logic [2:0]            state,
  output logic                  win_p,
  output logic                  lose_p
);

  // One extra bit so sums never wrap before saturation.
  localparam int CW1 = CREDIT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SPIN = 3'd1,
    S_EVAL = 3'd2,
    S_PAY  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t                     st, st_nxt;
  logic [15:0]                lfsr;
  logic [2:0]                 stop_idx, stop_nxt;
  logic [CREDIT_W-1:0]        credit_r, credit_nxt;
  logic [CREDIT_W-1:0]        payout_r, payout_nxt;
  logic                       win_r, lose_r, win_nxt, lose_nxt;
  logic                       load;
  logic [REELS-1:0][3:0]      reel_q;
  logic                       all_eq, pair_hit;
  logic [CW1-1:0]             eff, pay_sum;

  function automatic logic [CREDIT_W-1:0] sat(input logic [CW1-1:0] v);
    return (v > CW1'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : v[CREDIT_W-1:0];
  endfunction

  // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Per-reel lanes: a reel keeps running while its index is not yet stopped.
  for (genvar i = 0; i < REELS; i++) begin : g_reel
    logic [3:0] lv;
    logic       adv;
    assign lv  = 4'({1'b0, lfsr[4*i +: 4]} % 5'(SYMBOLS));
    assign adv = (st == S_SPIN) && tick && (3'(i) >= stop_idx);
    slot_reel #(.SYMBOLS(SYMBOLS)) u_reel (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (lv),
      .adv      (adv),
      .sym      (reel_q[i])
    );
  end

  // Jackpot detect: every reel matches reel 0.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < REELS; i++)
      if (reel_q[i] != reel_q[0]) all_eq = 1'b0;
  end

`ifdef SLOT_PAIR_PAY_EN
  // Any two reels showing the same symbol.
  always_comb begin
    pair_hit = 1'b0;
    for (int i = 0; i < REELS; i++)
      for (int j = i + 1; j < REELS; j++)
        if (reel_q[i] == reel_q[j]) pair_hit = 1'b1;
  end
`else
  assign pair_hit = 1'b0;
`endif

  assign eff     = {1'b0, credit_r} + CW1'(coin_p);
  assign pay_sum = {1'b0, credit_r} + {1'b0, payout_r} + CW1'(coin_p);

  // Next-state and datapath decode; a coin is folded into credit every cycle.
  always_comb begin
    st_nxt     = st;
    credit_nxt = sat(eff);
    payout_nxt = payout_r;
    stop_nxt   = stop_idx;
    win_nxt    = 1'b0;
    lose_nxt   = 1'b0;
    load       = 1'b0;
    case (st)
      S_IDLE: begin
        if (start_p && (eff >= CW1'(SPIN_COST))) begin
          credit_nxt = sat(eff - CW1'(SPIN_COST));
          load       = 1'b1;
          stop_nxt   = '0;
          st_nxt     = S_SPIN;
        end
      end
      S_SPIN: begin
        if (stop_p) begin
          stop_nxt = stop_idx + 3'd1;
          if (stop_idx == 3'(REELS - 1)) st_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        payout_nxt = all_eq   ? CREDIT_W'(JACKPOT_PAY) :
                     pair_hit ? CREDIT_W'(PAIR_PAY)    : '0;
        st_nxt     = S_PAY;
      end
      S_PAY: begin
        credit_nxt = sat(pay_sum);
        win_nxt    = (payout_r != '0);
        lose_nxt   = (payout_r == '0);
        st_nxt     = (sat(pay_sum) >= CREDIT_W'(SPIN_COST)) ? S_IDLE : S_OVER;
      end
      S_OVER: begin
        if (sat(eff) >= CREDIT_W'(SPIN_COST)) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, dropping any payout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      stop_idx <= '0;
      credit_r <= '0;
      payout_r <= '0;
      win_r    <= 1'b0;
      lose_r   <= 1'b0;
    end else begin
      st       <= st_nxt;
      stop_idx <= stop_nxt;
      credit_r <= credit_nxt;
      payout_r <= payout_nxt;
      win_r    <= win_nxt;
      lose_r   <= lose_nxt;
    end
  end

  assign reels  = reel_q;
  assign credit = credit_r;
  assign payout = payout_r;
  assign state  = st;
  assign win_p  = win_r;
  assign lose_p = lose_r;

endmodule

// File: tb/tb_slot_game_core.sv
// Randomized bench for slot_game_core against a cycle-level rule model.
module tb_slot_game_core;

  localparam int R = 3, S = 10, CW = 8, CMAX = 99, COST = 1, JP = 10, PP = 2;
`ifdef SLOT_PAIR_PAY_EN
  localparam bit PAIR_EN = 1'b1;
`else
  localparam bit PAIR_EN = 1'b0;
`endif

  logic clk = 0, rst_n = 0, coin_p = 0, start_p = 0, stop_p = 0, tick = 0;
  logic [4*R-1:0] reels;
  logic [CW-1:0]  credit, payout;
  logic [2:0]     state;
  logic           win_p, lose_p;

  int n_tests = 0, n_fail = 0;

  // reference model: states 0 idle,1 spin,2 eval,3 pay,4 over
  int          m_st, m_cr, m_pay, m_stop;
  int          m_reel[R];
  bit          m_win, m_lose;
  logic [15:0] m_lfsr;

  slot_game_core #(.REELS(R), .SYMBOLS(S), .CREDIT_W(CW), .CREDIT_MAX(CMAX),
                   .SPIN_COST(COST), .JACKPOT_PAY(JP), .PAIR_PAY(PP),
                   .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .coin_p(coin_p), .start_p(start_p),
    .stop_p(stop_p), .tick(tick), .reels(reels), .credit(credit),
    .payout(payout), .state(state), .win_p(win_p), .lose_p(lose_p));

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [4*R-1:0] exp_reels();
    logic [4*R-1:0] v;
    for (int i = 0; i < R; i++) v[4*i +: 4] = 4'(m_reel[i]);
    return v;
  endfunction

  function automatic logic [4*R-1:0] load_vals(input logic [15:0] l);
    logic [4*R-1:0] v;
    for (int i = 0; i < R; i++) v[4*i +: 4] = 4'(int'((l >> (4*i)) & 16'hF) % S);
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cr = 0; m_pay = 0; m_stop = 0; m_win = 0; m_lose = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < R; i++) m_reel[i] = 0;
  endtask

  task automatic model_step();
    int eff, npairs;
    eff = m_cr + int'(coin_p);
    m_win = 0; m_lose = 0;
    case (m_st)
      0: if (start_p && eff >= COST) begin
           m_cr = imin(eff - COST, CMAX);
           for (int i = 0; i < R; i++) m_reel[i] = int'((m_lfsr >> (4*i)) & 16'hF) % S;
           m_stop = 0; m_st = 1;
         end else m_cr = imin(eff, CMAX);
      1: begin
           m_cr = imin(eff, CMAX);
           if (tick) for (int i = m_stop; i < R; i++) m_reel[i] = (m_reel[i] + 1) % S;
           if (stop_p) begin m_stop++; if (m_stop == R) m_st = 2; end
         end
      2: begin
           m_cr = imin(eff, CMAX);
           npairs = 0;
           for (int i = 0; i < R; i++)
             for (int j = i + 1; j < R; j++) if (m_reel[i] == m_reel[j]) npairs++;
           if (npairs == R*(R-1)/2) m_pay = JP;
           else if (npairs > 0 && PAIR_EN) m_pay = PP;
           else m_pay = 0;
           m_st = 3;
         end
      3: begin
           m_cr = imin(m_cr + m_pay + int'(coin_p), CMAX);
           m_win = (m_pay > 0); m_lose = !m_win;
           m_st = (m_cr >= COST) ? 0 : 4;
         end
      default: begin
           m_cr = imin(eff, CMAX);
           if (m_cr >= COST) m_st = 0;
         end
    endcase
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive(input bit c, input bit st, input bit sp, input bit tk);
    coin_p = c; start_p = st; stop_p = sp; tick = tk;
    cyc();
    coin_p = 0; start_p = 0; stop_p = 0; tick = 0;
  endtask

  task automatic do_reset();
    coin_p = 0; start_p = 0; stop_p = 0; tick = 0;
    rst_n = 0; model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Runs the spin until the model leaves SPIN, stopping each reel on its target;
  // bad counts cycles where the DUT diverged from the model (plus a timeout).
  task automatic spin_to(input int t0, input int t1, input int t2, input bit rnd,
                         output int bad);
    int tgt[R];
    int nv, guard;
    bit tk, c, s, sp;
    tgt = '{t0, t1, t2}; bad = 0; guard = 0;
    while (m_st == 1 && guard < 300) begin
      tk = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c  = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      s  = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
      nv = tk ? (m_reel[m_stop] + 1) % S : m_reel[m_stop];
      sp = (nv == tgt[m_stop]);
      drive(c, s, sp, tk);
      if (reels !== exp_reels() || credit !== CW'(m_cr) || state !== 3'(m_st)) bad++;
      guard++;
    end
    if (guard >= 300) bad++;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (state !== 3'd0 || credit !== 8'd0 || payout !== 8'd0 || reels !== '0 ||
        win_p !== 1'b0 || lose_p !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d credit=%0d payout=%0d reels=%h win=%b lose=%b, want all zero",
               state, credit, payout, reels, win_p, lose_p);
    end
    drive(0, 1, 0, 0);
    n_tests++;
    if (state !== 3'd0 || credit !== 8'd0 || win_p !== 1'b0 || lose_p !== 1'b0) begin
      n_fail++;
      $display("FAIL start_no_credit: state=%0d credit=%0d win=%b lose=%b, want 0 0 0 0",
               state, credit, win_p, lose_p);
    end
    drive(0, 0, 1, 1);
    n_tests++;
    if (state !== 3'd0 || reels !== '0 || win_p !== 1'b0 || lose_p !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: state=%0d reels=%h win=%b lose=%b, want 0 000 0 0",
               state, reels, win_p, lose_p);
    end
  endtask

  task automatic test_coin_start();
    logic [4*R-1:0] lv;
    repeat (3) drive(1, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd3) begin
      n_fail++; $display("FAIL three_coins: credit=%0d want 3", credit);
    end
    lv = load_vals(m_lfsr);
    drive(0, 1, 0, 0);
    n_tests++;
    if (credit !== 8'd2 || state !== 3'd1 || reels !== lv) begin
      n_fail++;
      $display("FAIL start_load: credit=%0d state=%0d reels=%h, want 2 1 %h", credit, state, reels, lv);
    end
  endtask

  task automatic test_jackpot();
    int bad;
    spin_to(7, 7, 7, 1'b0, bad);
    n_tests++;
    if (bad !== 0 || state !== 3'd2 || reels !== 12'h777) begin
      n_fail++;
      $display("FAIL jackpot_stop: bad=%0d state=%0d reels=%h, want 0 2 777", bad, state, reels);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (state !== 3'd3 || payout !== 8'd10) begin
      n_fail++; $display("FAIL jackpot_payout: state=%0d payout=%0d, want 3 10", state, payout);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd12 || win_p !== 1'b1 || lose_p !== 1'b0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL jackpot_credit: credit=%0d win=%b lose=%b state=%0d, want 12 1 0 0",
               credit, win_p, lose_p, state);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (win_p !== 1'b0 || lose_p !== 1'b0) begin
      n_fail++; $display("FAIL win_one_cycle: win=%b lose=%b, want 0 0", win_p, lose_p);
    end
  endtask

  task automatic test_lose_over();
    int bad;
    do_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    n_tests++;
    if (credit !== 8'd0 || state !== 3'd1) begin
      n_fail++; $display("FAIL lose_start: credit=%0d state=%0d, want 0 1", credit, state);
    end
    spin_to(1, 2, 3, 1'b0, bad);
    drive(0, 0, 0, 0);
    n_tests++;
    if (bad !== 0 || payout !== 8'd0 || reels !== 12'h321) begin
      n_fail++; $display("FAIL lose_payout: bad=%0d payout=%0d reels=%h, want 0 0 321", bad, payout, reels);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (lose_p !== 1'b1 || win_p !== 1'b0 || credit !== 8'd0 || state !== 3'd4) begin
      n_fail++;
      $display("FAIL lose_over: lose=%b win=%b credit=%0d state=%0d, want 1 0 0 4", lose_p, win_p, credit, state);
    end
    drive(0, 1, 1, 1);
    n_tests++;
    if (state !== 3'd4 || credit !== 8'd0) begin
      n_fail++; $display("FAIL over_ignores_start: state=%0d credit=%0d, want 4 0", state, credit);
    end
    drive(1, 0, 0, 0);
    n_tests++;
    if (state !== 3'd0 || credit !== 8'd1) begin
      n_fail++; $display("FAIL over_coin: state=%0d credit=%0d, want 0 1", state, credit);
    end
  endtask

  task automatic test_pair();
    int bad;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    spin_to(4, 4, 9, 1'b1, bad);
    drive(0, 0, 0, 0);
    n_tests++;
    if (bad !== 0 || reels !== 12'h944 || payout !== (PAIR_EN ? 8'd2 : 8'd0)) begin
      n_fail++;
      $display("FAIL pair_payout: bad=%0d reels=%h payout=%0d, want 0 944 %0d", bad, reels, payout, PAIR_EN ? 2 : 0);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (win_p !== PAIR_EN || lose_p !== !PAIR_EN || credit !== CW'(m_cr)) begin
      n_fail++;
      $display("FAIL pair_result: win=%b lose=%b credit=%0d, want %b %b %0d", win_p, lose_p, credit,
               PAIR_EN, !PAIR_EN, m_cr);
    end
  endtask

  task automatic test_saturation();
    int bad;
    do_reset();
    repeat (98) drive(1, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd98) begin
      n_fail++; $display("FAIL coins_98: credit=%0d want 98", credit);
    end
    drive(0, 1, 0, 0);
    spin_to(7, 7, 7, 1'b0, bad);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    n_tests++;
    if (bad !== 0 || credit !== 8'd99 || win_p !== 1'b1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL pay_saturate: bad=%0d credit=%0d win=%b state=%0d, want 0 99 1 0", bad, credit, win_p, state);
    end
    drive(1, 0, 0, 0);
    n_tests++;
    if (credit !== 8'd99) begin
      n_fail++; $display("FAIL idle_saturate: credit=%0d want 99", credit);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    drive(0, 1, 0, 0);
    spin_to(2, 5, 8, 1'b0, bad);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);   // start in PAY is not a spin request
    n_tests++;
    if (bad !== 0 || state !== 3'd0 || lose_p !== 1'b1) begin
      n_fail++; $display("FAIL pay_ignores_start: bad=%0d state=%0d lose=%b, want 0 0 1", bad, state, lose_p);
    end
    drive(1, 1, 0, 0);
    n_tests++;
    if (state !== 3'd1 || lose_p !== 1'b0 || credit !== CW'(m_cr) || reels !== exp_reels()) begin
      n_fail++;
      $display("FAIL back_to_back: state=%0d lose=%b credit=%0d reels=%h, want 1 0 %0d %h",
               state, lose_p, credit, reels, m_cr, exp_reels());
    end
    spin_to(0, 0, 0, 1'b1, bad);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_tests++;
    if (bad !== 0 || credit !== CW'(m_cr) || win_p !== 1'b1) begin
      n_fail++; $display("FAIL b2b_jackpot: bad=%0d credit=%0d win=%b, want 0 %0d 1", bad, credit, win_p, m_cr);
    end
  endtask

  task automatic test_random();
    int bad, errs, wins;
    do_reset();
    repeat (12) drive(1, 0, 0, 0);
    errs = 0; wins = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_st == 4) drive(1, 0, 0, 0);
      drive(1'($urandom_range(0, 1)), 1, 0, 0);
      if (credit !== CW'(m_cr) || state !== 3'(m_st) || reels !== exp_reels()) errs++;
      if (m_st == 1) begin
        spin_to(int'($urandom_range(0, S-1)), int'($urandom_range(0, S-1)),
                int'($urandom_range(0, S-1)), 1'b1, bad);
        errs += bad;
        for (int c = 0; c < 2; c++) begin
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
          if (credit !== CW'(m_cr) || state !== 3'(m_st) || payout !== CW'(m_pay) ||
              win_p !== m_win || lose_p !== m_lose) errs++;
          if (m_win || m_lose) wins++;
        end
      end
    end
    n_tests++;
    if (errs !== 0 || wins !== 10) begin
      n_fail++; $display("FAIL random_spins: divergences=%0d results=%0d, want 0 10", errs, wins);
    end
  endtask

  task automatic test_reset_mid_spin();
    int pulses;
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    rst_n = 0; model_reset();
    #2;
    n_tests++;
    if (state !== 3'd0 || credit !== 8'd0 || payout !== 8'd0 || reels !== '0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d credit=%0d payout=%0d reels=%h, want 0 0 0 000",
               state, credit, payout, reels);
    end
    @(posedge clk); #1;
    rst_n = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1);
      if (win_p || lose_p || state !== 3'd0) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL reset_no_payout: bad_cycles=%0d want 0", pulses);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_coin_start();
    test_jackpot();
    test_lose_over();
    test_pair();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid_spin();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
